mem_port_arbiter: RTL and testbench

Shares the single-ported `Memory` between the instruction-fetch requester (`Fetcher`) and the data requester (MEM stage) of the five-stage core. Accepts at most one transaction at a time, issues it to memory, waits a fixed latency, and returns read data or a write acknowledgement to the winning requester. Data requests have fixed priority over fetch; an optional starvation guard bounds how long fetch can be locked out.

---
 rtl/mem_port_arbiter_if.sv | 45 ++++
 rtl/mem_port_arbiter.sv | 171 +++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 334 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the fetch requester, the data requester, the arbiter
// and the single-ported memory. The arbiter takes the slave view; the
// requesters plus the memory together form the master view.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_ready;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;

  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_ready;
  logic              d_rvalid;
  logic [DATA_W-1:0] d_rdata;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  if_req, if_addr,
    input  d_req, d_we, d_addr, d_wdata,
    input  mem_rdata,
    output if_ready, if_rvalid, if_rdata,
    output d_ready, d_rvalid, d_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output if_req, if_addr,
    output d_req, d_we, d_addr, d_wdata,
    output mem_rdata,
    input  if_ready, if_rvalid, if_rdata,
    input  d_ready, d_rvalid, d_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported memory between instruction
// fetch and the MEM-stage data port. One transaction in flight at a time:
// IDLE/DONE accept, ISSUE strobes the memory, WAIT covers the memory
// latency, DONE returns the response pulse. Data has priority over fetch.
//
// Optional feature macro: MEM_ARB_STARVE_GUARD_EN
//   defined   - after STARVE_LIMIT consecutive data grants while fetch is
//               waiting, the next contested grant goes to fetch.
//   undefined - strict data priority, no starvation counter.
module mem_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int MEM_LATENCY  = 1,
  parameter int STARVE_LIMIT = 4
) (
  input logic               clk,
  input logic               rst,
  mem_port_arbiter_if.slave bus
);

  localparam bit CFG_OK = (MEM_LATENCY >= 1) && (MEM_LATENCY <= 4) &&
                          (STARVE_LIMIT >= 1) && (STARVE_LIMIT <= 15) &&
                          (ADDR_W >= 1) && (DATA_W >= 1);

  if (!CFG_OK) begin : g_bad_cfg
    $error("mem_port_arbiter: MEM_LATENCY must be 1..4 and STARVE_LIMIT 1..15");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t            state_q;
  logic [2:0]        latCnt_q;
  logic              ownerData_q;
  logic              memEn_q;
  logic              memWe_q;
  logic [ADDR_W-1:0] memAddr_q;
  logic [DATA_W-1:0] memWdata_q;
  logic              ifRvalid_q;
  logic [DATA_W-1:0] ifRdata_q;
  logic              dRvalid_q;
  logic [DATA_W-1:0] dRdata_q;

  logic canAccept;
  logic starveHit;
  logic grantIf;
  logic grantD;

`ifdef MEM_ARB_STARVE_GUARD_EN
  logic [3:0] starveCnt_q;
  logic [3:0] starveCnt_d;
  assign starveHit = (starveCnt_q == 4'(STARVE_LIMIT));
`else
  assign starveHit = 1'b0;
`endif

  // Grant selection: only in IDLE/DONE, data wins a contest unless the
  // starvation guard has hit its limit; ready is held low while in reset
  // because a reset edge never accepts anything.
  always_comb begin
    canAccept = !rst && ((state_q == IDLE) || (state_q == DONE));
    grantIf   = 1'b0;
    grantD    = 1'b0;
    if (canAccept) begin
      if (bus.d_req && !(bus.if_req && starveHit)) begin
        grantD = 1'b1;
      end else if (bus.if_req) begin
        grantIf = 1'b1;
      end
    end
  end

  assign bus.if_ready  = grantIf;
  assign bus.d_ready   = grantD;
  assign bus.mem_en    = memEn_q;
  assign bus.mem_we    = memWe_q;
  assign bus.mem_addr  = memAddr_q;
  assign bus.mem_wdata = memWdata_q;
  assign bus.if_rvalid = ifRvalid_q;
  assign bus.if_rdata  = ifRdata_q;
  assign bus.d_rvalid  = dRvalid_q;
  assign bus.d_rdata   = dRdata_q;

  // Transaction FSM with registered memory strobes and response outputs;
  // the latency counter holds the WAIT cycles still to go minus one, so
  // the capture happens on the edge where it has reached zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      latCnt_q    <= '0;
      ownerData_q <= 1'b0;
      memEn_q     <= 1'b0;
      memWe_q     <= 1'b0;
      memAddr_q   <= '0;
      memWdata_q  <= '0;
      ifRvalid_q  <= 1'b0;
      ifRdata_q   <= '0;
      dRvalid_q   <= 1'b0;
      dRdata_q    <= '0;
    end else begin
      memEn_q    <= 1'b0;
      ifRvalid_q <= 1'b0;
      dRvalid_q  <= 1'b0;
      unique case (state_q)
        IDLE, DONE: begin
          if (grantIf || grantD) begin
            state_q     <= ISSUE;
            memEn_q     <= 1'b1;
            ownerData_q <= grantD;
            memAddr_q   <= grantD ? bus.d_addr : bus.if_addr;
            memWe_q     <= grantD && bus.d_we;
            memWdata_q  <= grantD ? bus.d_wdata : '0;
          end else begin
            state_q    <= IDLE;
            memWe_q    <= 1'b0;
            memAddr_q  <= '0;
            memWdata_q <= '0;
          end
        end
        ISSUE: begin
          state_q  <= WAIT;
          latCnt_q <= 3'(MEM_LATENCY - 1);
        end
        WAIT: begin
          if (latCnt_q == 3'd0) begin
            state_q <= DONE;
            if (ownerData_q) begin
              dRvalid_q <= 1'b1;
              dRdata_q  <= memWe_q ? '0 : bus.mem_rdata;
            end else begin
              ifRvalid_q <= 1'b1;
              ifRdata_q  <= bus.mem_rdata;
            end
          end else begin
            latCnt_q <= latCnt_q - 3'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef MEM_ARB_STARVE_GUARD_EN
  // Starvation counter next state: counts data wins over a waiting fetch,
  // cleared by a fetch grant or by an accept window with no fetch pending.
  always_comb begin
    starveCnt_d = starveCnt_q;
    if (grantIf) begin
      starveCnt_d = '0;
    end else if (grantD && bus.if_req) begin
      starveCnt_d = starveCnt_q + 4'd1;
    end else if (!bus.if_req && canAccept) begin
      starveCnt_d = '0;
    end
  end

  // Starvation counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      starveCnt_q <= '0;
    end else begin
      starveCnt_q <= starveCnt_d;
    end
  end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: a transaction-level model (accept edge
// plus fixed latency arithmetic) predicts every output each cycle, and
// directed sequences pin the model with hand-computed values.
module tb_mem_port_arbiter;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int ML     = 2;
  localparam int SL     = 2;

`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  mem_port_arbiter #(
    .ADDR_W      (ADDR_W),
    .DATA_W      (DATA_W),
    .MEM_LATENCY (ML),
    .STARVE_LIMIT(SL)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int testsRun    = 0;
  int testsFailed = 0;

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic checkText(input string name, input string actual, input string expected);
    testsRun++;
    if (actual != expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %s, expected %s", name, actual, expected);
    end
  endtask

  // Memory contents for words never written: an address-derived pattern.
  function automatic logic [DATA_W-1:0] defaultWord(input logic [ADDR_W-1:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  // Environment memory: samples mem_en on an edge, data appears ML cycles later.
  logic [DATA_W-1:0] envMem [logic [ADDR_W-1:0]];
  logic [DATA_W-1:0] rdPipe [ML];
  logic [DATA_W-1:0] envRd;

  always @(posedge clk) begin : envMemory
    envRd = $urandom();
    if (bus.mem_en) begin
      if (bus.mem_we) envMem[bus.mem_addr] = bus.mem_wdata;
      else envRd = envMem.exists(bus.mem_addr) ? envMem[bus.mem_addr] : defaultWord(bus.mem_addr);
    end
    for (int i = ML - 1; i > 0; i--) rdPipe[i] <= rdPipe[i-1];
    rdPipe[0] <= envRd;
  end

  assign bus.mem_rdata = rdPipe[ML-1];

  // Reference model state: the one transaction in flight, described by the
  // edge it was accepted on and its fields.
  logic [DATA_W-1:0] modelMem [logic [ADDR_W-1:0]];
  bit                started = 1'b0;
  int                cyc = 0;
  bit                txValid = 1'b0;
  bit                txData = 1'b0;
  bit                txWe = 1'b0;
  int                txAt = 0;
  logic [ADDR_W-1:0] txAddr = '0;
  logic [DATA_W-1:0] txWdata = '0;
  logic [DATA_W-1:0] expIfRdata = '0;
  logic [DATA_W-1:0] expDRdata = '0;
  int                starve = 0;
  bit                mActive, mDone, mFree, expIfReady, expDReady;

  function automatic logic [DATA_W-1:0] modelRead(input logic [ADDR_W-1:0] a);
    return modelMem.exists(a) ? modelMem[a] : defaultWord(a);
  endfunction

  task automatic preloadWord(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    envMem[a]   = d;
    modelMem[a] = d;
  endtask

  // Compare process: checks the current cycle's outputs, then advances the
  // model across the coming edge using the inputs now on the bus.
  always @(negedge clk) begin : modelCheck
    mActive = txValid && (cyc >= txAt) && (cyc <= txAt + 1 + ML);
    mDone   = txValid && (cyc == txAt + 1 + ML);
    if (started) begin
      checkOutput("mem_en",    64'(bus.mem_en),    64'(txValid && (cyc == txAt)));
      checkOutput("mem_we",    64'(bus.mem_we),    64'(mActive && txWe));
      checkOutput("mem_addr",  64'(bus.mem_addr),  mActive ? 64'(txAddr) : 64'd0);
      checkOutput("mem_wdata", 64'(bus.mem_wdata), mActive ? 64'(txWdata) : 64'd0);
      checkOutput("if_rvalid", 64'(bus.if_rvalid), 64'(mDone && !txData));
      checkOutput("d_rvalid",  64'(bus.d_rvalid),  64'(mDone && txData));
      checkOutput("if_rdata",  64'(bus.if_rdata),  64'(expIfRdata));
      checkOutput("d_rdata",   64'(bus.d_rdata),   64'(expDRdata));
    end

    mFree      = !txValid || (cyc + 1 >= txAt + 2 + ML);
    expIfReady = 1'b0;
    expDReady  = 1'b0;
    if (!rst && mFree) begin
      if (bus.if_req && bus.d_req) begin
        if (GUARD && starve == SL) expIfReady = 1'b1;
        else expDReady = 1'b1;
      end else begin
        expIfReady = bus.if_req;
        expDReady  = bus.d_req;
      end
    end
    if (started) begin
      checkOutput("if_ready", 64'(bus.if_ready), 64'(expIfReady));
      checkOutput("d_ready",  64'(bus.d_ready),  64'(expDReady));
    end

    if (rst) begin
      started    = 1'b1;
      txValid    = 1'b0;
      starve     = 0;
      expIfRdata = '0;
      expDRdata  = '0;
    end else begin
      if (txValid && (cyc + 1 == txAt + 1 + ML)) begin
        if (!txData) expIfRdata = modelRead(txAddr);
        else expDRdata = txWe ? '0 : modelRead(txAddr);
      end
      if (expIfReady) begin
        txValid = 1'b1; txData = 1'b0; txWe = 1'b0; txAt = cyc + 1;
        txAddr  = bus.if_addr; txWdata = '0;
        starve  = 0;
      end else if (expDReady) begin
        txValid = 1'b1; txData = 1'b1; txWe = bus.d_we; txAt = cyc + 1;
        txAddr  = bus.d_addr; txWdata = bus.d_wdata;
        if (txWe) modelMem[txAddr] = txWdata;
        starve  = bus.if_req ? starve + 1 : 0;
      end else if (!bus.if_req && mFree) begin
        starve = 0;
      end
    end
    cyc++;
  end

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input bit ifReq, input logic [ADDR_W-1:0] ifAddr,
                               input bit dReq, input bit dWe,
                               input logic [ADDR_W-1:0] dAddr,
                               input logic [DATA_W-1:0] dWdata);
    bus.if_req  = ifReq;
    bus.if_addr = ifAddr;
    bus.d_req   = dReq;
    bus.d_we    = dWe;
    bus.d_addr  = dAddr;
    bus.d_wdata = dWdata;
  endtask

  string order;
  int    count;
  bit    ifP, dP, dWeR, ifAcc, dAcc;
  logic [ADDR_W-1:0] ifA, dA;
  logic [DATA_W-1:0] dWd;

  initial begin
    applyStimulus(0, '0, 0, 0, '0, '0);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    checkOutput("reset mem_en",   64'(bus.mem_en),   64'd0);
    checkOutput("reset mem_addr", 64'(bus.mem_addr), 64'd0);
    checkOutput("reset d_rdata",  64'(bus.d_rdata),  64'd0);
    checkOutput("reset if_rdata", 64'(bus.if_rdata), 64'd0);

    // Single fetch from a preloaded word.
    preloadWord(32'h40, 32'hDEAD_BEEF);
    applyStimulus(1, 32'h40, 0, 0, '0, '0);
    #1 checkOutput("t1 if_ready", 64'(bus.if_ready), 64'd1);
    stepCycle();
    checkOutput("t1 mem_en", 64'(bus.mem_en), 64'd1);
    checkOutput("t1 mem_addr", 64'(bus.mem_addr), 64'h40);
    applyStimulus(0, '0, 0, 0, '0, '0);
    repeat (ML + 1) stepCycle();
    checkOutput("t1 if_rvalid", 64'(bus.if_rvalid), 64'd1);
    checkOutput("t1 if_rdata", 64'(bus.if_rdata), 64'hDEAD_BEEF);
    checkOutput("t1 d_rvalid", 64'(bus.d_rvalid), 64'd0);
    stepCycle();
    checkOutput("t1 if_rvalid end", 64'(bus.if_rvalid), 64'd0);
    checkOutput("t1 if_rdata hold", 64'(bus.if_rdata), 64'hDEAD_BEEF);

    // Store then load of the same word, the load accepted in the store's DONE.
    applyStimulus(0, '0, 1, 1, 32'h100, 32'h1234_5678);
    stepCycle();
    checkOutput("t2 store mem_we", 64'(bus.mem_we), 64'd1);
    applyStimulus(0, '0, 0, 0, '0, '0);
    repeat (ML + 1) stepCycle();
    checkOutput("t2 store d_rvalid", 64'(bus.d_rvalid), 64'd1);
    checkOutput("t2 store d_rdata", 64'(bus.d_rdata), 64'd0);
    applyStimulus(0, '0, 1, 0, 32'h100, '0);
    #1 checkOutput("t2 load ready in DONE", 64'(bus.d_ready), 64'd1);
    stepCycle();
    checkOutput("t2 load mem_en", 64'(bus.mem_en), 64'd1);
    applyStimulus(0, '0, 0, 0, '0, '0);
    repeat (ML + 1) stepCycle();
    checkOutput("t2 load d_rvalid", 64'(bus.d_rvalid), 64'd1);
    checkOutput("t2 load d_rdata", 64'(bus.d_rdata), 64'h1234_5678);
    stepCycle();

    // Simultaneous requests: data first, fetch taken in data's DONE.
    applyStimulus(1, 32'h200, 1, 0, 32'h300, '0);
    #1;
    checkOutput("t3 d_ready", 64'(bus.d_ready), 64'd1);
    checkOutput("t3 if_ready", 64'(bus.if_ready), 64'd0);
    stepCycle();
    checkOutput("t3 first addr", 64'(bus.mem_addr), 64'h300);
    applyStimulus(1, 32'h200, 0, 0, '0, '0);
    repeat (ML + 1) stepCycle();
    checkOutput("t3 d_rvalid", 64'(bus.d_rvalid), 64'd1);
    checkOutput("t3 if_ready in DONE", 64'(bus.if_ready), 64'd1);
    stepCycle();
    checkOutput("t3 fetch addr", 64'(bus.mem_addr), 64'h200);
    applyStimulus(0, '0, 0, 0, '0, '0);
    repeat (ML + 2) stepCycle();

    // Both requesters held high continuously: observe the grant order.
    applyStimulus(1, 32'h500, 1, 0, 32'h600, '0);
    order = "";
    for (int i = 0; i < 6 * (ML + 2) + 2 && order.len() < 6; i++) begin
      #1;
      if (bus.if_ready) order = {order, "I"};
      else if (bus.d_ready) order = {order, "D"};
      stepCycle();
    end
    checkText("t4 grant order", order, GUARD ? "DDIDDI" : "DDDDDD");
    applyStimulus(0, '0, 0, 0, '0, '0);
    repeat (ML + 3) stepCycle();

    // Reset in the middle of a load's WAIT.
    applyStimulus(0, '0, 1, 0, 32'h100, '0);
    stepCycle();
    applyStimulus(0, '0, 0, 0, '0, '0);
    stepCycle();
    rst = 1'b1;
    stepCycle();
    checkOutput("t5 mem_en", 64'(bus.mem_en), 64'd0);
    checkOutput("t5 mem_addr", 64'(bus.mem_addr), 64'd0);
    checkOutput("t5 d_rdata", 64'(bus.d_rdata), 64'd0);
    checkOutput("t5 if_rdata", 64'(bus.if_rdata), 64'd0);
    rst = 1'b0;
    count = 0;
    repeat (ML + 2) begin
      if (bus.d_rvalid) count++;
      stepCycle();
    end
    checkOutput("t5 no d_rvalid", 64'(count), 64'd0);
    applyStimulus(1, 32'h40, 0, 0, '0, '0);
    stepCycle();
    applyStimulus(0, '0, 0, 0, '0, '0);
    repeat (ML + 1) stepCycle();
    checkOutput("t5 fetch after reset", 64'(bus.if_rdata), 64'hDEAD_BEEF);
    stepCycle();

    // Data request raised in WAIT and withdrawn before DONE.
    applyStimulus(1, 32'h44, 0, 0, '0, '0);
    stepCycle();
    applyStimulus(0, '0, 0, 0, '0, '0);
    stepCycle();
    applyStimulus(0, '0, 1, 0, 32'h104, '0);
    #1 checkOutput("t6 d_ready in WAIT", 64'(bus.d_ready), 64'd0);
    count = 0;
    stepCycle();
    if (bus.mem_en) count++;
    applyStimulus(0, '0, 0, 0, '0, '0);
    repeat (ML + 3) begin
      stepCycle();
      if (bus.mem_en) count++;
    end
    checkOutput("t6 no extra mem_en", 64'(count), 64'd0);

    // Randomized traffic with withdrawals and occasional resets.
    ifP = 0; dP = 0; ifA = '0; dA = '0; dWd = '0; dWeR = 0;
    for (int i = 0; i < 600; i++) begin
      if (!ifP && $urandom_range(0, 2) == 0) begin
        ifP = 1;
        ifA = 32'h100 + 32'(4 * $urandom_range(0, 7));
      end
      if (!dP && $urandom_range(0, 2) == 0) begin
        dP   = 1;
        dWeR = 1'($urandom_range(0, 1));
        dA   = 32'h100 + 32'(4 * $urandom_range(0, 7));
        dWd  = $urandom();
      end
      if (ifP && $urandom_range(0, 15) == 0) ifP = 0;
      if (dP && $urandom_range(0, 15) == 0) dP = 0;
      rst = ($urandom_range(0, 99) == 0);
      applyStimulus(ifP, ifA, dP, dWeR, dA, dWd);
      #1;
      ifAcc = bus.if_ready && ifP;
      dAcc  = bus.d_ready && dP;
      @(posedge clk);
      #1;
      if (ifAcc) ifP = 0;
      if (dAcc) dP = 0;
    end
    rst = 1'b0;
    applyStimulus(0, '0, 0, 0, '0, '0);
    repeat (ML + 4) stepCycle();

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
